lsu_data_mem_ctrl: RTL and testbench
====================================

// Module: lsu_data_mem_ctrl
// PURPOSE
//  Load/store controller between the RISC-V core and data_mem.
//  - Turns a core load/store (funct3 size, byte address) into a word-aligned memory request with byte enables and lane-replicated write data.
//  - Stalls the core until the memory answers, then returns sign/zero-extended load data.
//  - Flags misaligned or illegal-size accesses without touching memory.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max WAIT cycles without mem_ready_i before abort; 0 = wait forever
// PORTS
//  clk_i        in   1   clock
//  rst_i        in   1   reset, asynchronous, active-high
//  core_req_i   in   1   core requests a memory access (held stable while core_stall_o=1)
//  core_we_i    in   1   1 = store, 0 = load
//  core_size_i  in   3   funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU; others illegal
//  core_addr_i  in   32  byte address
//  core_wd_i    in   32  store data (right-aligned)
//  core_rd_o    out  32  formatted load data, valid in cycle where stall drops on a load
//  core_stall_o out  1   1 = core must hold its request
//  core_err_o   out  1   1-cycle pulse: misaligned/illegal size, or timeout
//  mem_req_o    out  1   memory request
//  mem_we_o     out  1   memory write enable
//  mem_be_o     out  4   byte enables
//  mem_addr_o   out  32  = core_addr_i (pass-through; memory ignores addr[1:0])
//  mem_wd_o     out  32  lane-replicated write data
//  mem_rd_i     in   32  memory read word
//  mem_ready_i  in   1   memory response valid
// BEHAVIOUR
//  - FSM states IDLE, WAIT. Registers: state, off_q[1:0], size_q[2:0], we_q, tmo_cnt.
//  - Reset (async): state=IDLE, off_q=0, size_q=0, we_q=0, tmo_cnt=0, core_err_o=0. In IDLE with core_req_i=0 all outputs are 0.
//  - Legality check (combinational):
//    - illegal = size not in {0,1,2,4,5};
//    - misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0.
//  - IDLE, core_req_i=1, legal:
//    - mem_req_o=1, mem_we_o=core_we_i, core_stall_o=1.
//    - Latch off/size/we. Next state WAIT, tmo_cnt=0.
//  - IDLE, core_req_i=1, illegal/misaligned:
//    - mem_req_o=0, core_stall_o=0.
//    - core_err_o=1 next cycle (registered, 1 cycle). Stays IDLE.
//  - Byte enables:
//    - B/BU: 4'b0001<<off.
//    - H/HU: 4'b0011<<off.
//    - W: 4'b1111.
//    - mem_be_o=0 when mem_req_o=0.
//  - Write data:
//    - B: {4{wd[7:0]}}.
//    - H: {2{wd[15:0]}}.
//    - W: wd.
//  - WAIT: mem_req_o=0 (memory holds its read data when not requested).
//    - mem_ready_i=1: core_stall_o=0. For loads, core_rd_o = format(mem_rd_i, off_q, size_q). Next state IDLE.
//    - mem_ready_i=0: core_stall_o=1, tmo_cnt++.
//    - TIMEOUT_CYCLES!=0 and tmo_cnt reaches TIMEOUT_CYCLES-1 with ready low: next state IDLE, core_err_o=1 for 1 cycle, core_stall_o=0 that cycle, core_rd_o=0.
//  - Load format:
//    - B: sext(byte[off_q]); BU: zext.
//    - H: sext(half[off_q[1]]); HU: zext.
//    - W: mem_rd_i.
//    - core_rd_o=0 outside the completion cycle of a load.
//  - Latency: every legal access is exactly 2 cycles (1 stall cycle) with data_mem (ready tied 1). Stores also pass through WAIT.
//  - core_req_i/inputs in WAIT are ignored; a new request is accepted only in IDLE. Back-to-back requests: IDLE->WAIT->IDLE->WAIT, no bubble beyond the stall cycle.
//  - Reset during WAIT: return to IDLE immediately, stall drops, no error pulse. A store already sampled by memory stays committed.
// TESTING
//  - sw addr=0x10 wd=0xDEADBEEF: cycle0 req=1 we=1 be=1111 wd=0xDEADBEEF stall=1; cycle1 stall=0.
//  - sb addr=0x13 wd=0x000000A5: be=1000, mem_wd=0xA5A5A5A5; then lw 0x10 -> rd=0xA5ADBEEF.
//  - lb 0x13 -> rd=0xFFFFFFA5; lbu 0x13 -> 0x000000A5; lh 0x12 -> 0xFFFFA5AD; lhu 0x12 -> 0x0000A5AD.
//  - lw addr=0x12 or lh addr=0x11 or size=3: mem_req_o never 1, stall=0, core_err_o single pulse.
//  - TIMEOUT_CYCLES=4, mem_ready_i=0 forever: stall high 4 cycles after launch, then err pulse, back to IDLE.
//  - rst_i asserted mid-WAIT with ready low: stall=0 same cycle (async), state IDLE, next lw works normally.

Source files
------------

// File: rtl/lsu_data_mem_ctrl.sv
// lsu_data_mem_ctrl: core load/store to word-aligned data_mem requests, stall until ready, format load data
module lsu_data_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_d;
    logic [1:0] off_q;
    logic [2:0] size_q;
    logic we_q;
    logic [TW-1:0] tmo_cnt;
    logic illegal, misaligned, launch, reject, timeout, done;
    logic [7:0] lb;
    logic [15:0] lh;

    assign illegal = !(core_size_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    assign misaligned = (core_size_i[1:0] == 2'd1 && core_addr_i[0]) ||
                        (core_size_i == 3'd2 && core_addr_i[1:0] != 2'b00);
    assign launch = state == IDLE && core_req_i && !illegal && !misaligned;
    assign reject = state == IDLE && core_req_i && (illegal || misaligned);
    assign timeout = TIMEOUT_CYCLES != 0 && state == WAIT && !mem_ready_i &&
                     tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign done = state == WAIT && mem_ready_i;

    // state and access context; error is a registered one-cycle pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            off_q      <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            tmo_cnt    <= '0;
            core_err_o <= 1'b0;
        end else begin
            state      <= state_d;
            core_err_o <= reject || timeout;
            if (launch) begin
                off_q   <= core_addr_i[1:0];
                size_q  <= core_size_i;
                we_q    <= core_we_i;
                tmo_cnt <= '0;
            end else if (state == WAIT && !mem_ready_i) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    // next state: launch into WAIT, leave on response or timeout
    always_comb begin
        state_d = launch ? WAIT : (done || timeout) ? IDLE : state;
    end

    // request shaping and load formatting
    always_comb begin
        mem_req_o    = launch;
        mem_we_o     = launch && core_we_i;
        mem_addr_o   = launch ? core_addr_i : '0;
        mem_be_o     = !launch ? 4'b0000 : core_size_i[1] ? 4'b1111 :
                       core_size_i[0] ? 4'b0011 << core_addr_i[1:0] : 4'b0001 << core_addr_i[1:0];
        mem_wd_o     = !launch ? '0 : core_size_i[1] ? core_wd_i :
                       core_size_i[0] ? {2{core_wd_i[15:0]}} : {4{core_wd_i[7:0]}};
        core_stall_o = launch || (state == WAIT && !mem_ready_i && !timeout);
        lb           = mem_rd_i[{off_q, 3'b000} +: 8];
        lh           = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        core_rd_o    = !(done && !we_q) ? '0 : size_q[1] ? mem_rd_i :
                       size_q[0] ? {{16{lh[15] & !size_q[2]}}, lh} : {{24{lb[7] & !size_q[2]}}, lb};
    end
endmodule

// File: tb/tb_lsu_data_mem_ctrl.sv
// tb_lsu_data_mem_ctrl: directed checks of the load/store controller against a small data memory
module tb_lsu_data_mem_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = '0;
    logic [31:0] core_addr_i = '0;
    logic [31:0] core_wd_i = '0;
    logic [31:0] core_rd_o;
    logic        core_stall_o, core_err_o, mem_req_o, mem_we_o, mem_ready_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
    logic        ready_en = 1'b1;
    logic [31:0] mem [64];
    logic [31:0] rdata = '0;
    int vectors = 0;
    int miscompares = 0;

    lsu_data_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .core_req_i(core_req_i), .core_we_i(core_we_i),
        .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
        .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .core_err_o(core_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
        .mem_ready_i(mem_ready_i)
    );

    assign mem_ready_i = ready_en;
    assign mem_rd_i = rdata;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mem_req_o) begin
            rdata <= mem[mem_addr_o[7:2]];
            if (mem_we_o)
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) mem[mem_addr_o[7:2]][8*b +: 8] <= mem_wd_o[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = sz;
        core_addr_i = a;
        core_wd_i   = wd;
    endtask

    task automatic access(input string tag, input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input logic [31:0] ewd,
                          input logic [31:0] erd);
        drive(we, sz, a, wd);
        #2;
        chk({tag, "_req"}, 32'(mem_req_o), 32'd1);
        chk({tag, "_stall1"}, 32'(core_stall_o), 32'd1);
        chk({tag, "_we"}, 32'(mem_we_o), 32'(we));
        chk({tag, "_be"}, 32'(mem_be_o), 32'(be));
        chk({tag, "_addr"}, mem_addr_o, a);
        if (we) chk({tag, "_wd"}, mem_wd_o, ewd);
        tick;
        chk({tag, "_stall0"}, 32'(core_stall_o), 32'd0);
        chk({tag, "_wait_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_rd"}, core_rd_o, erd);
        tick;
        chk({tag, "_err"}, 32'(core_err_o), 32'd0);
    endtask

    task automatic bad(input string tag, input logic we, input logic [2:0] sz, input logic [31:0] a);
        drive(we, sz, a, 32'h1234_5678);
        #2;
        chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_stall"}, 32'(core_stall_o), 32'd0);
        chk({tag, "_be"}, 32'(mem_be_o), 32'd0);
        tick;
        core_req_i = 1'b0;
        #1;
        chk({tag, "_err1"}, 32'(core_err_o), 32'd1);
        chk({tag, "_req_after"}, 32'(mem_req_o), 32'd0);
        tick;
        chk({tag, "_err0"}, 32'(core_err_o), 32'd0);
    endtask

    initial begin
        foreach (mem[i]) mem[i] = '0;
        tick;
        tick;
        chk("rst_stall", 32'(core_stall_o), 32'd0);
        chk("rst_err", 32'(core_err_o), 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        #2 rst_i = 1'b0;
        tick;
        chk("idle_be", 32'(mem_be_o), 32'd0);
        chk("idle_rd", core_rd_o, 32'd0);
        chk("idle_wd", mem_wd_o, 32'd0);

        access("sw10", 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        access("sb13", 1'b1, 3'd0, 32'h13, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        access("lw10", 1'b0, 3'd2, 32'h10, 32'h0, 4'b1111, 32'h0, 32'hA5AD_BEEF);
        access("lb13", 1'b0, 3'd0, 32'h13, 32'h0, 4'b1000, 32'h0, 32'hFFFF_FFA5);
        access("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, 4'b1000, 32'h0, 32'h0000_00A5);
        access("lh12", 1'b0, 3'd1, 32'h12, 32'h0, 4'b1100, 32'h0, 32'hFFFF_A5AD);
        access("lhu12", 1'b0, 3'd5, 32'h12, 32'h0, 4'b1100, 32'h0, 32'h0000_A5AD);
        access("lh10", 1'b0, 3'd1, 32'h10, 32'h0, 4'b0011, 32'h0, 32'hFFFF_BEEF);
        access("sh16", 1'b1, 3'd1, 32'h16, 32'hCAFE_7F01, 4'b1100, 32'h7F01_7F01, 32'h0);
        access("lh16", 1'b0, 3'd1, 32'h16, 32'h0, 4'b1100, 32'h0, 32'h0000_7F01);
        access("lb16", 1'b0, 3'd0, 32'h16, 32'h0, 4'b0100, 32'h0, 32'h0000_0001);
        access("lb17", 1'b0, 3'd0, 32'h17, 32'h0, 4'b1000, 32'h0, 32'h0000_007F);
        access("lhu14", 1'b0, 3'd5, 32'h14, 32'h0, 4'b0011, 32'h0, 32'h0);
        access("sb11", 1'b1, 3'd0, 32'h11, 32'h0000_0080, 4'b0010, 32'h8080_8080, 32'h0);
        access("lb11", 1'b0, 3'd0, 32'h11, 32'h0, 4'b0010, 32'h0, 32'hFFFF_FF80);
        core_req_i = 1'b0;
        #1;
        chk("idle_after_req", 32'(mem_req_o), 32'd0);

        bad("lw12", 1'b0, 3'd2, 32'h12);
        bad("lh11", 1'b0, 3'd1, 32'h11);
        bad("size3", 1'b0, 3'd3, 32'h10);
        bad("size7", 1'b1, 3'd7, 32'h10);
        bad("sw11", 1'b1, 3'd2, 32'h11);
        bad("hu13", 1'b0, 3'd5, 32'h13);

        ready_en = 1'b0;
        drive(1'b0, 3'd2, 32'h10, 32'h0);
        #2;
        chk("tmo_launch_stall", 32'(core_stall_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("tmo_wait_stall", 32'(core_stall_o), 32'd1);
            chk("tmo_wait_req", 32'(mem_req_o), 32'd0);
            chk("tmo_wait_err", 32'(core_err_o), 32'd0);
        end
        tick;
        chk("tmo_last_stall", 32'(core_stall_o), 32'd0);
        chk("tmo_last_rd", core_rd_o, 32'd0);
        core_req_i = 1'b0;
        tick;
        chk("tmo_err1", 32'(core_err_o), 32'd1);
        chk("tmo_idle_stall", 32'(core_stall_o), 32'd0);
        tick;
        chk("tmo_err0", 32'(core_err_o), 32'd0);

        drive(1'b0, 3'd2, 32'h10, 32'h0);
        tick;
        core_req_i = 1'b0;
        #1;
        chk("rstw_stall_before", 32'(core_stall_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("rstw_stall_async", 32'(core_stall_o), 32'd0);
        chk("rstw_err", 32'(core_err_o), 32'd0);
        #2 rst_i = 1'b0;
        tick;
        chk("rstw_err_after", 32'(core_err_o), 32'd0);
        chk("rstw_idle_stall", 32'(core_stall_o), 32'd0);
        ready_en = 1'b1;
        access("lw_after_rst", 1'b0, 3'd2, 32'h10, 32'h0, 4'b1111, 32'h0, 32'hA5AD_80EF);
        core_req_i = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
